// File: rtl/elevator_pkg.sv
// elevator_pkg: shared direction type and default sizing for the elevator call path
package elevator_pkg;

    localparam int FLOORS_DEF  = 8;
    localparam int FLOOR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } dir_e;

endpackage

// File: rtl/call_scan_mask.sv
// call_scan_mask: splits the merged request vector into above / below / at the current floor
module call_scan_mask
    import elevator_pkg::*;
#(
    parameter int FLOORS  = FLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF
) (
    input  logic [FLOORS-1:0]  req,
    input  logic [FLOOR_W-1:0] floor,
    output logic               above,
    output logic               below,
    output logic               here
);

    // An out-of-range floor never matches, so everything counts as below and nothing as here
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (req[i] && i > int'(floor)) above = 1'b1;
            if (req[i] && i < int'(floor)) below = 1'b1;
            if (req[i] && i == int'(floor)) here = 1'b1;
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// call_scheduler: latches hall/car calls, picks SCAN direction, flags stops and clears served calls
// Optional: REQ_CANCEL_EN makes a car button press toggle its call so a lit button can be cancelled.
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS  = FLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  upcall_in,
    input  logic [FLOORS-1:0]  downcall_in,
    input  logic [FLOORS-1:0]  car_btn_in,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               at_floor,
    output logic [FLOORS-1:0]  up_req,
    output logic [FLOORS-1:0]  down_req,
    output logic [FLOORS-1:0]  car_req,
    output logic               nextup,
    output logic               nextdown,
    output logic               stop_here,
    output logic               pending
);

    dir_e              dir_q, dir_d;
    logic [FLOORS-1:0] up_q, up_d, down_q, down_d, car_q, car_d;
    logic [FLOORS-1:0] any_req, floor_oh, car_next;
    logic              stop_q, stop_d, pend_q, pend_d;
    logic              above, below, here;
    logic              up_here, down_here, car_here, clr_up, clr_down;

    assign any_req = up_q | down_q | car_q;

    call_scan_mask #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_mask (
        .req   (any_req),
        .floor (floor),
        .above (above),
        .below (below),
        .here  (here)
    );

`ifdef REQ_CANCEL_EN
    logic [FLOORS-1:0] btn_q;

    // Previous car button levels, used to find press edges
    always_ff @(posedge clk) begin
        if (rst) btn_q <= '0;
        else     btn_q <= car_btn_in;
    end

    assign car_next = car_q ^ (car_btn_in & ~btn_q);
`else
    assign car_next = car_q | car_btn_in;
`endif

    // Next direction, request vectors, and the registered stop/pending flags
    always_comb begin
        floor_oh = '0;
        for (int i = 0; i < FLOORS; i++) floor_oh[i] = (int'(floor) == i);
        up_here   = |(up_q & floor_oh);
        down_here = |(down_q & floor_oh);
        car_here  = |(car_q & floor_oh);
        clr_up    = at_floor && (dir_q != DOWN || !below);
        clr_down  = at_floor && (dir_q != UP || !above);
        up_d      = (up_q | upcall_in) & ~({FLOORS{clr_up}} & floor_oh);
        down_d    = (down_q | downcall_in) & ~({FLOORS{clr_down}} & floor_oh);
        car_d     = car_next & ~({FLOORS{at_floor}} & floor_oh);
        dir_d     = IDLE;
        case (dir_q)
            IDLE:    dir_d = above ? UP : below ? DOWN : IDLE;
            UP:      dir_d = above ? UP : below ? DOWN : IDLE;
            DOWN:    dir_d = below ? DOWN : above ? UP : IDLE;
            default: dir_d = IDLE;
        endcase
        stop_d = car_here
              || (dir_q == UP && (up_here || (!above && down_here)))
              || (dir_q == DOWN && (down_here || (!below && up_here)))
              || (dir_q == IDLE && here);
        pend_d = |any_req;
    end

    // State registers; reset drops every call and returns to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            up_q   <= '0;
            down_q <= '0;
            car_q  <= '0;
            dir_q  <= IDLE;
            stop_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            up_q   <= up_d;
            down_q <= down_d;
            car_q  <= car_d;
            dir_q  <= dir_d;
            stop_q <= stop_d;
            pend_q <= pend_d;
        end
    end

    assign up_req    = up_q;
    assign down_req  = down_q;
    assign car_req   = car_q;
    assign nextup    = (dir_q == UP);
    assign nextdown  = (dir_q == DOWN);
    assign stop_here = stop_q;
    assign pending   = pend_q;

endmodule
